// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_host_tx                                                  |
// | Description : Host-to-device PS/2 transmitter. Sends one command byte to   |
// |               the keyboard over the open-drain clock/data pair: inhibit,   |
// |               start bit, 8 data bits LSB first, odd parity, stop, ACK.     |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               tx_data[7:0], tx_start  -> request a byte                    |
// |               tx_busy, tx_done, tx_error -> status / terminal pulses       |
// |               ps2_clk_i, ps2_dat_i    -> raw line levels                   |
// |               ps2_clk_oe, ps2_dat_oe  -> 1 = pull the line low             |
// | Options     : `define PS2_HOST_TX_RETRY_EN to retry a failed frame up to   |
// |               twice before reporting tx_error.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One down-counter serves both the inhibit interval and the ACK timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_LEN - 1);
  localparam logic [FLT_W-1:0] FLT_ONE      = FLT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SEND      = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             clk_meta_q, clk_sync_q;
  logic             dat_meta_q, dat_sync_q;
  logic             clk_filt_q, clk_filt_d;
  logic             clk_prev_q;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic clk_fall;
  logic timeout;
  logic fail;

  // Glitch filter: the filtered level only follows the synchronized clock
  // after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        clk_filt_d = clk_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_ONE;
      end
    end
  end

  assign clk_fall = clk_prev_q & ~clk_filt_q;
  assign timeout  = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    busy_d    = busy_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      IDLE: begin
        // A request landing on the terminal-pulse cycle is dropped.
        if (tx_start && !done_q && !error_q) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          dat_oe_d  = 1'b0;
          cnt_d     = INHIBIT_LOAD;
          state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      INHIBIT: begin
        // Start bit goes out on the last inhibit cycle, one cycle before
        // the clock is released.
        if (cnt_q <= CNT_ONE) begin
          dat_oe_d = 1'b1;
        end
        if (cnt_q == '0) begin
          clk_oe_d  = 1'b0;
          cnt_d     = TIMEOUT_LOAD;
          bit_idx_d = 4'd0;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      SEND: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (clk_fall) begin
            if (bit_idx_q < 4'd8) begin
              dat_oe_d = ~shift_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              dat_oe_d = ~parity_q;
            end else begin
              dat_oe_d = 1'b0;
              state_d  = ACK;
            end
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ACK: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (clk_fall) begin
            if (!dat_sync_q) begin
              state_d = WAIT_IDLE;
            end else begin
              fail = 1'b1;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (clk_filt_q && dat_sync_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        clk_oe_d = 1'b1;
        cnt_d    = INHIBIT_LOAD;
        state_d  = INHIBIT;
      end else begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
`else
      error_d = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      flt_cnt_q  <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      clk_filt_q <= clk_filt_d;
      clk_prev_q <= clk_filt_q;
      flt_cnt_q  <= flt_cnt_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_host_tx                                               |
// | Description : Self-checking bench for ps2_host_tx with a PS/2 device model |
// |               on the open-drain lines and a scoreboard of expected frames. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;
  localparam int FLT = 8;
  localparam int H   = 16;  // device half clock period, in clk cycles
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_i, ps2_dat_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // Open-drain wired-AND of host and device pulls.
  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Pulse / inhibit-phase monitor.
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   inh_cnt   = 0;
  int   pulse_bad = 0;
  logic busy_prev   = 1'b0;
  logic clk_oe_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if ((tx_done || tx_error) && (tx_busy || !busy_prev)) pulse_bad <= pulse_bad + 1;
    if (ps2_clk_oe && !clk_oe_prev) inh_cnt <= inh_cnt + 1;
    busy_prev   <= tx_busy;
    clk_oe_prev <= ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Odd parity by counting ones: parity is 1 when the byte has an even count.
  function automatic logic odd_par(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2 == 0);
  endfunction

  task automatic send(input logic [7:0] d, input bit accepted);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    if (accepted) sb.push_back('{data: d, par: odd_par(d)});
  endtask

  // Measures how many cycles the host holds the clock low; returns the data
  // pull state seen at the first released-clock sample.
  task automatic wait_inhibit(output int len, output logic start_bit);
    int g = 0;
    len = 0;
    while (!ps2_clk_oe && g < 200) begin
      @(negedge clk);
      g++;
    end
    while (ps2_clk_oe && len < 10 * INH) begin
      @(negedge clk);
      len++;
    end
    start_bit = ps2_dat_oe;
  endtask

  // Device clocks 10 bits in (read at the end of each low phase), then
  // answers on the 11th clock with ACK (data low) or NACK (data left high).
  task automatic run_frame(input bit ack, input bit pop);
    logic [9:0] b;
    exp_t       e;
    repeat (2 * H) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      b[k] = ps2_dat_i;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_dat_low = ack;
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    chk("sb_has_entry", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb[0];
      if (pop) sb.delete(0);
      chk("frame_data", b[7:0], e.data);
      chk("frame_parity", b[8], e.par);
      chk("frame_stop", b[9], 1);
    end
  endtask

  task automatic wait_end();
    int g = 0;
    while (tx_busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("busy_release_bound", 32'(g < 3000), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic normal_frame(input logic [7:0] d, input string tag);
    int   len;
    logic sbit;
    int   d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(d, 1'b1);
    wait_inhibit(len, sbit);
    chk({tag, "_inhibit_len"}, len, INH);
    chk({tag, "_start_bit"}, sbit, 1);
    run_frame(1'b1, 1'b1);
    wait_end();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_no_error"}, err_cnt - e0, 0);
    chk({tag, "_released"}, {tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   len;
    logic sbit;
    int   d0, e0, i0, k;

    reset_n  = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Command byte 0xED with ACK: bits 1,0,1,1,0,1,1,1, parity 1.
    normal_frame(8'hED, "xED");

    // Parity coverage.
    normal_frame(8'h00, "x00");
    normal_frame(8'hFF, "xFF");

    // 0x07 (parity 0); a start pulsed on the tx_done cycle must be dropped.
    d0 = done_cnt;
    i0 = inh_cnt;
    send(8'h07, 1'b1);
    wait_inhibit(len, sbit);
    run_frame(1'b1, 1'b1);
    k = 0;
    while (!(tx_done || tx_error) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("x07_terminal_is_done", tx_done, 1);
    tx_data  = 8'h99;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("start_on_done_ignored", inh_cnt - i0, 1);
    chk("x07_done_once", done_cnt - d0, 1);

    // NACK: device leaves data high on the 11th clock.
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    send(8'h3C, 1'b1);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_inhibit(len, sbit);
      run_frame(1'b0, a == ATTEMPTS - 1);
    end
    wait_end();
    chk("nack_error_once", err_cnt - e0, 1);
    chk("nack_no_done", done_cnt - d0, 0);
    chk("nack_inhibit_phases", inh_cnt - i0, ATTEMPTS);
    chk("nack_released", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);

    // Silent device: error exactly TMO cycles after clock release.
    e0 = err_cnt;
    send(8'h5A, 1'b1);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_inhibit(len, sbit);
      k = 0;
      while (!tx_error && !ps2_clk_oe && k < TMO + 100) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_cycles", k, TMO);
    end
    chk("timeout_busy_low", tx_busy, 0);
    sb.delete();
    repeat (4) @(negedge clk);
    chk("timeout_error_once", err_cnt - e0, 1);
    chk("timeout_released", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Request while busy is lost: only 0x55 goes out.
    d0 = done_cnt;
    i0 = inh_cnt;
    send(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    send(8'h12, 1'b0);
    wait_inhibit(len, sbit);
    run_frame(1'b1, 1'b1);
    wait_end();
    repeat (60) @(negedge clk);
    chk("busy_start_ignored", inh_cnt - i0, 1);
    chk("busy_frame_done", done_cnt - d0, 1);

    // Reset in the middle of SEND releases everything at once, no pulse.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hAB, 1'b1);
    wait_inhibit(len, sbit);
    repeat (2 * H) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    chk("pre_reset_busy_dat", {tx_busy, ps2_dat_oe}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("reset_async_release", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    normal_frame(8'hF4, "xF4");

    chk("pulse_with_busy_drop", pulse_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
